// File: rtl/wave_settings_bank_pkg.sv
// Shared definitions for the function-generator settings bank:
// FSM encoding, reset defaults and a width helper.
package wave_settings_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CHECK     = 2'd1,
    ST_WAIT_SYNC = 2'd2,
    ST_COMMIT    = 2'd3
  } state_t;

  localparam int DUTY_RST     = 50;
  localparam int DUTY_MAX_DEF = 100;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wave_settings_channel.sv
// Active settings registers of one output channel; loaded as a whole
// when the bank commits a validated request to this channel.
module wave_settings_channel
  import wave_settings_bank_pkg::*;
#(
  parameter int AMP_W  = 12,
  parameter int DUTY_W = 7,
  parameter int FDES_W = 17,
  parameter int FSET_W = 28,
  parameter int WAVE_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_we,
  input  logic [AMP_W-1:0]  i_max,
  input  logic [AMP_W-1:0]  i_min,
  input  logic [DUTY_W-1:0] i_duty,
  input  logic [FDES_W-1:0] i_fdes,
  input  logic [FSET_W-1:0] i_fset,
  input  logic [WAVE_W-1:0] i_wave,
  output logic [AMP_W-1:0]  o_max,
  output logic [AMP_W-1:0]  o_min,
  output logic [DUTY_W-1:0] o_duty,
  output logic [FDES_W-1:0] o_fdes,
  output logic [FSET_W-1:0] o_fset,
  output logic [WAVE_W-1:0] o_wave
);

  logic [AMP_W-1:0]  r_max;
  logic [AMP_W-1:0]  r_min;
  logic [DUTY_W-1:0] r_duty;
  logic [FDES_W-1:0] r_fdes;
  logic [FSET_W-1:0] r_fset;
  logic [WAVE_W-1:0] r_wave;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_max  <= '1;
      r_min  <= '0;
      r_duty <= DUTY_W'(DUTY_RST);
      r_fdes <= '0;
      r_fset <= '0;
      r_wave <= '0;
    end else if (i_we) begin
      r_max  <= i_max;
      r_min  <= i_min;
      r_duty <= i_duty;
      r_fdes <= i_fdes;
      r_fset <= i_fset;
      r_wave <= i_wave;
    end
  end

  assign o_max  = r_max;
  assign o_min  = r_min;
  assign o_duty = r_duty;
  assign o_fdes = r_fdes;
  assign o_fset = r_fset;
  assign o_wave = r_wave;

endmodule

// File: rtl/wave_settings_bank.sv
// Multi-channel settings bank: captures a request on the rising edge of load,
// validates it, and commits it immediately or at the channel's period end.
module wave_settings_bank
  import wave_settings_bank_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int AMP_W        = 12,
  parameter int DUTY_W       = 7,
  parameter int FDES_W       = 17,
  parameter int FSET_W       = 28,
  parameter int WAVE_W       = 2,
  parameter int DUTY_MAX     = DUTY_MAX_DEF,
  parameter int SYNC_TIMEOUT = 1024,
  localparam int CH_W        = clog2_min1(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic [CH_W-1:0]          ch_sel,
  input  logic                     sync_mode,
  input  logic [AMP_W-1:0]         maximum,
  input  logic [AMP_W-1:0]         minimum,
  input  logic [DUTY_W-1:0]        duty_cycle,
  input  logic [FDES_W-1:0]        desired_frequency,
  input  logic [FSET_W-1:0]        frequency_setting,
  input  logic [WAVE_W-1:0]        waveform,
  input  logic [NUM_CH-1:0]        period_end,
  output logic [NUM_CH*AMP_W-1:0]  max_bus,
  output logic [NUM_CH*AMP_W-1:0]  min_bus,
  output logic [NUM_CH*DUTY_W-1:0] duty_bus,
  output logic [NUM_CH*FDES_W-1:0] freq_desired_bus,
  output logic [NUM_CH*FSET_W-1:0] freq_set_bus,
  output logic [NUM_CH*WAVE_W-1:0] wave_bus,
  output logic                     busy,
  output logic                     load_done,
  output logic                     load_err,
  output logic [NUM_CH-1:0]        updated
);

  localparam int TMR_W = clog2_min1(SYNC_TIMEOUT);

  state_t            r_state;
  logic              r_load_q;
  logic [AMP_W-1:0]  r_max;
  logic [AMP_W-1:0]  r_min;
  logic [DUTY_W-1:0] r_duty;
  logic [FDES_W-1:0] r_fdes;
  logic [FSET_W-1:0] r_fset;
  logic [WAVE_W-1:0] r_wave;
  logic [CH_W-1:0]   r_ch;
  logic              r_sync;
  logic [TMR_W-1:0]  r_timer;
  logic              r_busy;
  logic              r_load_done;
  logic              r_load_err;
  logic [NUM_CH-1:0] r_updated;

  logic              w_load_edge;
  logic              w_invalid;
  logic              w_pe_hit;
  logic              w_timeout;
  logic [NUM_CH-1:0] w_ch_hot;

  assign w_load_edge = load & ~r_load_q;
  assign w_invalid   = (r_min > r_max) || (int'(r_duty) > DUTY_MAX) || (int'(r_ch) >= NUM_CH);
  // Only the staged channel's strobe can release a synchronised commit.
  assign w_pe_hit    = |(period_end & w_ch_hot);
  assign w_timeout   = (r_timer == TMR_W'(SYNC_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_load_q    <= 1'b0;
      r_ch        <= '0;
      r_sync      <= 1'b0;
      r_timer     <= '0;
      r_busy      <= 1'b0;
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
      r_updated   <= '0;
    end else begin
      r_load_q    <= load;
      r_load_done <= 1'b0;
      r_updated   <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_load_edge) begin
            r_max   <= maximum;
            r_min   <= minimum;
            r_duty  <= duty_cycle;
            r_fdes  <= desired_frequency;
            r_fset  <= frequency_setting;
            r_wave  <= waveform;
            r_ch    <= ch_sel;
            r_sync  <= sync_mode;
            r_busy  <= 1'b1;
            r_state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (w_invalid) begin
            r_load_err  <= 1'b1;
            r_load_done <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end else begin
            r_load_err <= 1'b0;
            r_timer    <= '0;
            r_state    <= r_sync ? ST_WAIT_SYNC : ST_COMMIT;
          end
        end
        ST_WAIT_SYNC: begin
          if (w_pe_hit || w_timeout) begin
            r_state <= ST_COMMIT;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_COMMIT: begin
          r_updated   <= w_ch_hot;
          r_load_done <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign w_ch_hot[gi] = (r_ch == CH_W'(gi));

      wave_settings_channel #(
        .AMP_W  (AMP_W),
        .DUTY_W (DUTY_W),
        .FDES_W (FDES_W),
        .FSET_W (FSET_W),
        .WAVE_W (WAVE_W)
      ) u_channel (
        .clk    (clk),
        .reset  (reset),
        .i_we   ((r_state == ST_COMMIT) && w_ch_hot[gi]),
        .i_max  (r_max),
        .i_min  (r_min),
        .i_duty (r_duty),
        .i_fdes (r_fdes),
        .i_fset (r_fset),
        .i_wave (r_wave),
        .o_max  (max_bus[gi*AMP_W +: AMP_W]),
        .o_min  (min_bus[gi*AMP_W +: AMP_W]),
        .o_duty (duty_bus[gi*DUTY_W +: DUTY_W]),
        .o_fdes (freq_desired_bus[gi*FDES_W +: FDES_W]),
        .o_fset (freq_set_bus[gi*FSET_W +: FSET_W]),
        .o_wave (wave_bus[gi*WAVE_W +: WAVE_W])
      );
    end
  endgenerate

  assign busy      = r_busy;
  assign load_done = r_load_done;
  assign load_err  = r_load_err;
  assign updated   = r_updated;

endmodule

// File: tb/tb_wave_settings_bank.sv
// Scoreboard bench for wave_settings_bank: each load pushes its expected
// completion (cycle, status, bus contents); the monitor pops on load_done.
module tb_wave_settings_bank;

  localparam int NUM_CH = 2;
  localparam int T      = 48;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [0:0]  ch_sel;
  logic        sync_mode;
  logic [11:0] maximum, minimum;
  logic [6:0]  duty_cycle;
  logic [16:0] desired_frequency;
  logic [27:0] frequency_setting;
  logic [1:0]  waveform;
  logic [1:0]  period_end;
  logic [23:0] max_bus, min_bus;
  logic [13:0] duty_bus;
  logic [33:0] freq_desired_bus;
  logic [55:0] freq_set_bus;
  logic [3:0]  wave_bus;
  logic        busy, load_done, load_err;
  logic [1:0]  updated;

  wave_settings_bank #(
    .NUM_CH(NUM_CH), .AMP_W(12), .DUTY_W(7), .FDES_W(17), .FSET_W(28),
    .WAVE_W(2), .DUTY_MAX(100), .SYNC_TIMEOUT(T)
  ) dut (
    .clk(clk), .reset(reset), .load(load), .ch_sel(ch_sel), .sync_mode(sync_mode),
    .maximum(maximum), .minimum(minimum), .duty_cycle(duty_cycle),
    .desired_frequency(desired_frequency), .frequency_setting(frequency_setting),
    .waveform(waveform), .period_end(period_end),
    .max_bus(max_bus), .min_bus(min_bus), .duty_bus(duty_bus),
    .freq_desired_bus(freq_desired_bus), .freq_set_bus(freq_set_bus),
    .wave_bus(wave_bus), .busy(busy), .load_done(load_done),
    .load_err(load_err), .updated(updated)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          done_cyc;
    bit          err;
    logic [1:0]  upd;
    logic [23:0] mx, mn;
    logic [13:0] du;
    logic [33:0] fd;
    logic [55:0] fs;
    logic [3:0]  wv;
  } exp_t;

  exp_t sb[$];

  logic [11:0] m_max[NUM_CH], m_min[NUM_CH];
  logic [6:0]  m_duty[NUM_CH];
  logic [16:0] m_fd[NUM_CH];
  logic [27:0] m_fs[NUM_CH];
  logic [1:0]  m_wv[NUM_CH];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_max[i] = 12'hFFF; m_min[i] = '0; m_duty[i] = 7'd50;
      m_fd[i] = '0; m_fs[i] = '0; m_wv[i] = '0;
    end
  endtask

  function automatic exp_t snap();
    exp_t e;
    e.done_cyc = 0; e.err = 1'b0; e.upd = '0;
    e.mx = {m_max[1], m_max[0]};
    e.mn = {m_min[1], m_min[0]};
    e.du = {m_duty[1], m_duty[0]};
    e.fd = {m_fd[1], m_fd[0]};
    e.fs = {m_fs[1], m_fs[0]};
    e.wv = {m_wv[1], m_wv[0]};
    return e;
  endfunction

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_err"},  64'(load_err), 64'd0);
    check_eq({tag, "_upd"},  64'(updated), 64'd0);
    check_eq({tag, "_max"},  64'(max_bus), 64'hFFFFFF);
    check_eq({tag, "_min"},  64'(min_bus), 64'd0);
    check_eq({tag, "_duty"}, 64'(duty_bus), 64'({7'd50, 7'd50}));
    check_eq({tag, "_fd"},   64'(freq_desired_bus), 64'd0);
    check_eq({tag, "_fs"},   64'(freq_set_bus), 64'd0);
    check_eq({tag, "_wv"},   64'(wave_bus), 64'd0);
  endtask

  // Drives one request; pe_k is the edge (after E0) carrying period_end for the
  // target channel, 0 if none is sent.
  task automatic do_load(input int ch, input bit sm, input int mx, input int mn, input int du,
                         input logic [16:0] fd, input logic [27:0] fs, input logic [1:0] wv,
                         input int pe_k, input bit expect_done, output int n0);
    bit   valid;
    int   lat;
    exp_t e;
    valid = (mn <= mx) && (du <= 100) && (ch < NUM_CH);
    lat   = !valid ? 1 : (!sm ? 2 : ((pe_k > 0) ? pe_k + 1 : T + 2));
    @(negedge clk);
    ch_sel = 1'(ch); sync_mode = sm; maximum = 12'(mx); minimum = 12'(mn);
    duty_cycle = 7'(du); desired_frequency = fd; frequency_setting = fs; waveform = wv;
    load = 1'b1;
    n0 = cyc + 1;
    if (expect_done) begin
      if (valid) begin
        m_max[ch] = 12'(mx); m_min[ch] = 12'(mn); m_duty[ch] = 7'(du);
        m_fd[ch] = fd; m_fs[ch] = fs; m_wv[ch] = wv;
      end
      e = snap();
      e.done_cyc = n0 + lat;
      e.err = !valid;
      e.upd = valid ? (2'b01 << ch) : 2'b00;
      sb.push_back(e);
    end
    @(negedge clk);
    check_eq("busy_e0", 64'(busy), 64'd1);
    load = 1'b0;
    // Inputs changing after capture must not leak into the commit.
    ch_sel = ~ch_sel; sync_mode = ~sm; maximum = 12'($urandom); minimum = 12'($urandom);
    duty_cycle = 7'($urandom); desired_frequency = 17'($urandom);
    frequency_setting = 28'($urandom); waveform = 2'($urandom);
  endtask

  task automatic pulse_pe(input int idx, input int at);
    while (cyc < at - 1) @(negedge clk);
    period_end[idx] = 1'b1;
    @(negedge clk);
    period_end[idx] = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check_eq("drain", 64'(sb.size()), 64'd0);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (load_done) begin
        if (sb.size() == 0) begin
          check_eq("done_unexp", 64'(load_done), 64'd0);
        end else begin
          e = sb.pop_front();
          $display("txn done cyc=%0d err=%0b upd=%b", cyc, load_err, updated);
          check_eq("done_cyc", 64'(cyc), 64'(e.done_cyc));
          check_eq("load_err", 64'(load_err), 64'(e.err));
          check_eq("updated",  64'(updated), 64'(e.upd));
          check_eq("busy_done", 64'(busy), 64'd0);
          check_eq("max_bus",  64'(max_bus), 64'(e.mx));
          check_eq("min_bus",  64'(min_bus), 64'(e.mn));
          check_eq("duty_bus", 64'(duty_bus), 64'(e.du));
          check_eq("fd_bus",   64'(freq_desired_bus), 64'(e.fd));
          check_eq("fs_bus",   64'(freq_set_bus), 64'(e.fs));
          check_eq("wv_bus",   64'(wave_bus), 64'(e.wv));
        end
      end else if (updated != 2'b00) begin
        check_eq("upd_no_done", 64'(updated), 64'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0;
    reset = 1'b1; load = 1'b0; ch_sel = '0; sync_mode = 1'b0;
    maximum = '0; minimum = '0; duty_cycle = '0; desired_frequency = '0;
    frequency_setting = '0; waveform = '0; period_end = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    mon_en = 1'b1;
    @(negedge clk);
    check_reset_state("rst");

    // Immediate commit to channel 1; channel 0 must keep reset values.
    do_load(1, 0, 3000, 500, 30, 17'd12345, 28'd1000000, 2'd2, 0, 1, n0);
    wait_idle(10);

    // Synchronised commit on channel 0; channel 1 strobe must be ignored.
    do_load(0, 1, 4000, 100, 75, 17'd777, 28'd123456, 2'd3, 40, 1, n0);
    pulse_pe(1, n0 + 10);
    check_eq("busy_wait", 64'(busy), 64'd1);
    pulse_pe(0, n0 + 40);
    wait_idle(60);

    // Rejected requests leave outputs alone; a valid one clears the error.
    do_load(0, 0, 700, 800, 40, 17'd1, 28'd2, 2'd1, 0, 1, n0);
    wait_idle(10);
    check_eq("err_sticky", 64'(load_err), 64'd1);
    do_load(1, 0, 900, 900, 101, 17'd3, 28'd4, 2'd0, 0, 1, n0);
    wait_idle(10);
    do_load(0, 0, 1234, 1234, 100, 17'd99, 28'd88, 2'd1, 0, 1, n0);
    wait_idle(10);
    check_eq("err_cleared", 64'(load_err), 64'd0);

    // Forced commit after the timeout; a second edge while busy is dropped.
    do_load(1, 1, 2048, 16, 10, 17'd4242, 28'd5555, 2'd3, 0, 1, n0);
    while (cyc < n0 + 5) @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_idle(T + 10);
    repeat (4) @(negedge clk);

    // Reset in WAIT_SYNC aborts the transaction with no completion.
    do_load(0, 1, 100, 50, 20, 17'd8, 28'd9, 2'd2, 0, 0, n0);
    while (cyc < n0 + 10) @(negedge clk);
    check_eq("busy_pre_rst", 64'(busy), 64'd1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    check_reset_state("rst_mid");
    repeat (T + 5) @(negedge clk);

    do_load(0, 0, 3500, 200, 60, 17'd31, 28'd64, 2'd1, 0, 1, n0);
    wait_idle(10);
    check_eq("sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
